// File: rtl/data_c_rr_arbiter_if.sv
// Bundle of the NUM upstream valid/ready/data/last streams and the single
// arbitrated downstream stream with its source-ID side band.
interface data_c_rr_arbiter_if #(
    parameter int NUM   = 4,
    parameter int DSIZE = 8
);
    localparam int IDSIZE = $clog2(NUM);

    logic [NUM-1:0]       s_en;
    logic [NUM-1:0]       s_valid;
    logic [NUM*DSIZE-1:0] s_data;
    logic [NUM-1:0]       s_last;
    logic [NUM-1:0]       s_ready;
    logic                 m_valid;
    logic [DSIZE-1:0]     m_data;
    logic                 m_last;
    logic [IDSIZE-1:0]    m_id;
    logic                 m_ready;
    logic                 busy;

    modport slave (
        input  s_en, s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last, m_id, busy
    );

    modport master (
        output s_en, s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last, m_id, busy
    );
endinterface

// File: rtl/data_c_rr_arbiter.sv
// Packet-level round-robin arbiter: locks onto one source for a whole packet
// and forwards it through a single registered output stage tagged with its ID.
module data_c_rr_arbiter #(
    parameter int NUM   = 4,
    parameter int DSIZE = 8
) (
    input  logic                clock,
    input  logic                rst_n,
    data_c_rr_arbiter_if.slave  bus
);
    localparam int IDSIZE = $clog2(NUM);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]        state;
    logic [IDSIZE-1:0] grant;
    logic [IDSIZE-1:0] ptr;
    logic              busy_q;

    logic              vld_p0;
    logic [DSIZE-1:0]  m_data_p0;
    logic              m_last_p0;
    logic [IDSIZE-1:0] m_id_p0;

    logic [NUM-1:0]    req;
    logic [NUM-1:0]    s_ready_vec;
    logic              ready_g;
    logic              take;
    logic [DSIZE-1:0]  s_data_g;
    logic              s_last_g;

    // First requester strictly after ptr, wrapping modulo NUM.
    function automatic logic [IDSIZE-1:0] rr_pick(
        input logic [NUM-1:0]    r,
        input logic [IDSIZE-1:0] p
    );
        logic [IDSIZE-1:0] pick;
        logic [IDSIZE-1:0] idx;
        pick = '0;
        for (int k = NUM; k >= 1; k--) begin
            idx = IDSIZE'((int'(p) + k) % NUM);
            if (r[idx]) pick = idx;
        end
        return pick;
    endfunction

    assign req      = bus.s_valid & bus.s_en;
    assign ready_g  = !vld_p0 || bus.m_ready;
    assign s_data_g = bus.s_data[int'(grant)*DSIZE +: DSIZE];
    assign s_last_g = bus.s_last[grant];
    assign take     = (state == ST_LOCK) && bus.s_valid[grant] && ready_g;

    always_comb begin
        s_ready_vec = '0;
        if (state == ST_LOCK) s_ready_vec[grant] = ready_g;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            grant  <= '0;
            ptr    <= IDSIZE'(NUM - 1);
            busy_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        grant  <= rr_pick(req, ptr);
                        state  <= ST_LOCK;
                        busy_q <= 1'b1;
                    end
                end
                default: begin
                    // s_en is not consulted here: a packet always runs to its last beat.
                    if (take && s_last_g) begin
                        ptr    <= grant;
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Stage p0: registered output beat; load and drain may coincide without a bubble.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0    <= 1'b0;
            m_data_p0 <= '0;
            m_last_p0 <= 1'b0;
            m_id_p0   <= '0;
        end else if (take) begin
            vld_p0    <= 1'b1;
            m_data_p0 <= s_data_g;
            m_last_p0 <= s_last_g;
            m_id_p0   <= grant;
        end else if (vld_p0 && bus.m_ready) begin
            vld_p0    <= 1'b0;
        end
    end

    assign bus.s_ready = s_ready_vec;
    assign bus.m_valid = vld_p0;
    assign bus.m_data  = m_data_p0;
    assign bus.m_last  = m_last_p0;
    assign bus.m_id    = m_id_p0;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_data_c_rr_arbiter.sv
// Directed bench for data_c_rr_arbiter: cycle table plus hand-written
// sequences for backpressure, lock holding, enable masking and reset.
module tb_data_c_rr_arbiter;
    logic clock;
    logic rst_n;
    int   total;
    int   passed;

    data_c_rr_arbiter_if #(.NUM(4), .DSIZE(8)) bus ();

    data_c_rr_arbiter #(.NUM(4), .DSIZE(8)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  en;
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        logic        mready;
        logic        ev;
        logic [7:0]  ed;
        logic        el;
        logic [1:0]  eid;
        logic        eb;
        logic [3:0]  esr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] en, input logic [3:0] valid,
                                input logic [31:0] data, input logic [3:0] last,
                                input logic mready, input logic ev, input logic [7:0] ed,
                                input logic el, input logic [1:0] eid, input logic eb,
                                input logic [3:0] esr);
        vec_t v;
        v.en = en; v.valid = valid; v.data = data; v.last = last; v.mready = mready;
        v.ev = ev; v.ed = ed; v.el = el; v.eid = eid; v.eb = eb; v.esr = esr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic [3:0] en, input logic [3:0] valid,
                         input logic [31:0] data, input logic [3:0] last, input logic mready);
        bus.s_en    = en;
        bus.s_valid = valid;
        bus.s_data  = data;
        bus.s_last  = last;
        bus.m_ready = mready;
    endtask

    task automatic check_beat(input string tag, input logic [7:0] d, input logic l,
                              input logic [1:0] id);
        check({tag, " m_valid"}, 32'(bus.m_valid), 32'd1);
        check({tag, " m_data"},  32'(bus.m_data),  32'(d));
        check({tag, " m_last"},  32'(bus.m_last),  32'(l));
        check({tag, " m_id"},    32'(bus.m_id),    32'(id));
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst_n  = 1'b0;
        drive(4'h0, 4'h0, 32'h0, 4'h0, 1'b1);

        // 3-beat packet from source 0
        vecs.push_back(mk(4'hF, 4'h1, 32'h11, 4'h0, 1, 0, 8'h00, 0, 0, 0, 4'h0));
        vecs.push_back(mk(4'hF, 4'h1, 32'h11, 4'h0, 1, 0, 8'h00, 0, 0, 1, 4'h1));
        vecs.push_back(mk(4'hF, 4'h1, 32'h22, 4'h0, 1, 1, 8'h11, 0, 0, 1, 4'h1));
        vecs.push_back(mk(4'hF, 4'h1, 32'h33, 4'h1, 1, 1, 8'h22, 0, 0, 1, 4'h1));
        vecs.push_back(mk(4'hF, 4'h0, 32'h33, 4'h0, 1, 1, 8'h33, 1, 0, 0, 4'h0));
        vecs.push_back(mk(4'hF, 4'h0, 32'h00, 4'h0, 1, 0, 8'h00, 0, 0, 0, 4'h0));
        // all four sources, single-beat packets, rotation 1,2,3,0,1
        vecs.push_back(mk(4'hF, 4'hF, 32'hB3B2B1B0, 4'hF, 1, 0, 8'h00, 0, 0, 0, 4'h0));
        vecs.push_back(mk(4'hF, 4'hF, 32'hB3B2B1B0, 4'hF, 1, 0, 8'h00, 0, 0, 1, 4'h2));
        vecs.push_back(mk(4'hF, 4'hF, 32'hB3B2B1B0, 4'hF, 1, 1, 8'hB1, 1, 1, 0, 4'h0));
        vecs.push_back(mk(4'hF, 4'hF, 32'hB3B2B1B0, 4'hF, 1, 0, 8'h00, 0, 0, 1, 4'h4));
        vecs.push_back(mk(4'hF, 4'hF, 32'hB3B2B1B0, 4'hF, 1, 1, 8'hB2, 1, 2, 0, 4'h0));
        vecs.push_back(mk(4'hF, 4'hF, 32'hB3B2B1B0, 4'hF, 1, 0, 8'h00, 0, 0, 1, 4'h8));
        vecs.push_back(mk(4'hF, 4'hF, 32'hB3B2B1B0, 4'hF, 1, 1, 8'hB3, 1, 3, 0, 4'h0));
        vecs.push_back(mk(4'hF, 4'hF, 32'hB3B2B1B0, 4'hF, 1, 0, 8'h00, 0, 0, 1, 4'h1));
        vecs.push_back(mk(4'hF, 4'hF, 32'hB3B2B1B0, 4'hF, 1, 1, 8'hB0, 1, 0, 0, 4'h0));
        vecs.push_back(mk(4'hF, 4'hF, 32'hB3B2B1B0, 4'hF, 1, 0, 8'h00, 0, 0, 1, 4'h2));
        vecs.push_back(mk(4'hF, 4'h0, 32'hB3B2B1B0, 4'hF, 1, 1, 8'hB1, 1, 1, 0, 4'h0));
        vecs.push_back(mk(4'hF, 4'h0, 32'hB3B2B1B0, 4'hF, 1, 0, 8'h00, 0, 0, 0, 4'h0));
        // source 2 masked off by s_en
        vecs.push_back(mk(4'hB, 4'hF, 32'hB3B2B1B0, 4'hF, 1, 0, 8'h00, 0, 0, 0, 4'h0));
        vecs.push_back(mk(4'hB, 4'hF, 32'hB3B2B1B0, 4'hF, 1, 0, 8'h00, 0, 0, 1, 4'h8));
        vecs.push_back(mk(4'hB, 4'hF, 32'hB3B2B1B0, 4'hF, 1, 1, 8'hB3, 1, 3, 0, 4'h0));
        vecs.push_back(mk(4'hB, 4'hF, 32'hB3B2B1B0, 4'hF, 1, 0, 8'h00, 0, 0, 1, 4'h1));
        vecs.push_back(mk(4'hB, 4'hF, 32'hB3B2B1B0, 4'hF, 1, 1, 8'hB0, 1, 0, 0, 4'h0));
        vecs.push_back(mk(4'hB, 4'hF, 32'hB3B2B1B0, 4'hF, 1, 0, 8'h00, 0, 0, 1, 4'h2));
        vecs.push_back(mk(4'hB, 4'hF, 32'hB3B2B1B0, 4'hF, 1, 1, 8'hB1, 1, 1, 0, 4'h0));
        vecs.push_back(mk(4'hB, 4'h8, 32'hB3B2B1B0, 4'hF, 1, 0, 8'h00, 0, 0, 1, 4'h8));
        vecs.push_back(mk(4'hB, 4'h0, 32'hB3B2B1B0, 4'hF, 1, 1, 8'hB3, 1, 3, 0, 4'h0));
        vecs.push_back(mk(4'hB, 4'h0, 32'hB3B2B1B0, 4'hF, 1, 0, 8'h00, 0, 0, 0, 4'h0));

        repeat (2) @(negedge clock);
        check("reset m_valid", 32'(bus.m_valid), 32'd0);
        check("reset m_data",  32'(bus.m_data),  32'd0);
        check("reset m_last",  32'(bus.m_last),  32'd0);
        check("reset m_id",    32'(bus.m_id),    32'd0);
        check("reset busy",    32'(bus.busy),    32'd0);
        check("reset s_ready", 32'(bus.s_ready), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            drive(vecs[i].en, vecs[i].valid, vecs[i].data, vecs[i].last, vecs[i].mready);
            #1;
            check($sformatf("row%0d s_ready", i), 32'(bus.s_ready), 32'(vecs[i].esr));
            check($sformatf("row%0d busy", i),    32'(bus.busy),    32'(vecs[i].eb));
            check($sformatf("row%0d m_valid", i), 32'(bus.m_valid), 32'(vecs[i].ev));
            if (vecs[i].ev) begin
                check($sformatf("row%0d m_data", i), 32'(bus.m_data), 32'(vecs[i].ed));
                check($sformatf("row%0d m_last", i), 32'(bus.m_last), 32'(vecs[i].el));
                check($sformatf("row%0d m_id", i),   32'(bus.m_id),   32'(vecs[i].eid));
            end
        end

        // Backpressure: source 0 beat A5 held for 5 stalled cycles, then 5A with no bubble.
        @(negedge clock); drive(4'hF, 4'h1, 32'hA5, 4'h0, 1'b0); #1;
        check("bp idle s_ready", 32'(bus.s_ready), 32'h0);
        @(negedge clock); #1;
        check("bp grant s_ready", 32'(bus.s_ready), 32'h1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock); drive(4'hF, 4'h1, 32'h5A, 4'h1, 1'b0); #1;
            check_beat($sformatf("bp stall%0d", k), 8'hA5, 1'b0, 2'd0);
            check($sformatf("bp stall%0d s_ready", k), 32'(bus.s_ready), 32'h0);
            check($sformatf("bp stall%0d busy", k), 32'(bus.busy), 32'd1);
        end
        @(negedge clock); bus.m_ready = 1'b1; #1;
        check("bp release s_ready", 32'(bus.s_ready), 32'h1);
        check_beat("bp release", 8'hA5, 1'b0, 2'd0);
        @(negedge clock); bus.s_valid = 4'h0; #1;
        check_beat("bp next", 8'h5A, 1'b1, 2'd0);
        check("bp next busy", 32'(bus.busy), 32'd0);
        @(negedge clock); #1;
        check("bp drained", 32'(bus.m_valid), 32'd0);

        // Source 2 locked for 4 beats while source 1 requests from beat 2.
        @(negedge clock); drive(4'hF, 4'h4, 32'h00C00000, 4'h0, 1'b1); #1;
        check("lock idle s_ready", 32'(bus.s_ready), 32'h0);
        @(negedge clock); #1;
        check("lock b0 s_ready", 32'(bus.s_ready), 32'h4);
        @(negedge clock); drive(4'hF, 4'h6, 32'h00C1D000, 4'h2, 1'b1); #1;
        check("lock b1 s_ready", 32'(bus.s_ready), 32'h4);
        check_beat("lock b1", 8'hC0, 1'b0, 2'd2);
        @(negedge clock); drive(4'hF, 4'h6, 32'h00C2D000, 4'h2, 1'b1); #1;
        check("lock b2 s_ready", 32'(bus.s_ready), 32'h4);
        check_beat("lock b2", 8'hC1, 1'b0, 2'd2);
        @(negedge clock); drive(4'hF, 4'h6, 32'h00C3D000, 4'h6, 1'b1); #1;
        check("lock b3 s_ready", 32'(bus.s_ready), 32'h4);
        check_beat("lock b3", 8'hC2, 1'b0, 2'd2);
        @(negedge clock); drive(4'hF, 4'h2, 32'h0000D000, 4'h2, 1'b1); #1;
        check("lock end s_ready", 32'(bus.s_ready), 32'h0);
        check("lock end busy", 32'(bus.busy), 32'd0);
        check_beat("lock end", 8'hC3, 1'b1, 2'd2);
        @(negedge clock); #1;
        check("lock next s_ready", 32'(bus.s_ready), 32'h2);
        check("lock next m_valid", 32'(bus.m_valid), 32'd0);
        @(negedge clock); bus.s_valid = 4'h0; #1;
        check_beat("lock next", 8'hD0, 1'b1, 2'd1);

        // s_en for source 0 dropped mid-packet; packet still completes.
        @(negedge clock); drive(4'hF, 4'h1, 32'hE0, 4'h0, 1'b1); #1;
        check("en idle m_valid", 32'(bus.m_valid), 32'd0);
        @(negedge clock); #1;
        check("en b0 s_ready", 32'(bus.s_ready), 32'h1);
        @(negedge clock); drive(4'hE, 4'h1, 32'hE1, 4'h0, 1'b1); #1;
        check("en b1 s_ready", 32'(bus.s_ready), 32'h1);
        check_beat("en b1", 8'hE0, 1'b0, 2'd0);
        @(negedge clock); drive(4'hE, 4'h1, 32'hE2, 4'h1, 1'b1); #1;
        check("en b2 s_ready", 32'(bus.s_ready), 32'h1);
        check_beat("en b2", 8'hE1, 1'b0, 2'd0);
        @(negedge clock); drive(4'hF, 4'h0, 32'h0, 4'h0, 1'b1); #1;
        check_beat("en end", 8'hE2, 1'b1, 2'd0);
        @(negedge clock); #1;
        check("en drained", 32'(bus.m_valid), 32'd0);

        // Reset during a source 3 packet; source 0 then wins since ptr returns to 3.
        @(negedge clock); drive(4'hF, 4'h8, 32'hF0000000, 4'h0, 1'b1); #1;
        @(negedge clock); #1;
        check("rst grant s_ready", 32'(bus.s_ready), 32'h8);
        @(negedge clock); bus.s_data = 32'hF1000000; #1;
        check_beat("rst b1", 8'hF0, 1'b0, 2'd3);
        @(negedge clock); bus.s_data = 32'hF2000000; #1;
        check_beat("rst b2", 8'hF1, 1'b0, 2'd3);
        rst_n = 1'b0; #1;
        check("rst m_valid", 32'(bus.m_valid), 32'd0);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst s_ready", 32'(bus.s_ready), 32'h0);
        @(negedge clock); rst_n = 1'b1; drive(4'hF, 4'h9, 32'hF30000AA, 4'h0, 1'b1); #1;
        check("post rst s_ready", 32'(bus.s_ready), 32'h0);
        @(negedge clock); #1;
        check("post rst grant", 32'(bus.s_ready), 32'h1);
        check("post rst busy", 32'(bus.busy), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
